core_if_fetch: RTL and testbench

Instruction fetch unit. It owns the architectural PC, issues single-outstanding fetch requests to instruction memory, and captures the returned word. It presents each instruction with its PC to the decode stage over a valid/ready handshake. It accepts redirects from branch/jump resolution and drops any in-flight or buffered fetch made stale by a redirect.

---
 rtl/core_if_fetch.sv | 179 +++++++++++++++++
 tb/tb_core_if_fetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/core_if_fetch.sv
// Instruction fetch unit: owns the PC, keeps one fetch outstanding, and hands words to decode.
// Optional macro CORE_IF_MISALIGN_CHK_EN traps misaligned redirect targets instead of fetching them.
module core_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            o_ifu_req_valid,
    input  logic            i_ifu_req_ready,
    output logic [XLEN-1:0] o_ifu_req_addr,
    input  logic            i_ifu_rsp_valid,
    output logic            o_ifu_rsp_ready,
    input  logic [XLEN-1:0] i_ifu_rsp_inst,
    output logic            o_if_valid,
    input  logic            i_id_ready,
    output logic [XLEN-1:0] o_if_inst,
    output logic [XLEN-1:0] o_if_pc,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_halt,
    output logic            o_if_misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, opc_q;
    logic            kill_q, kill_d;
    logic            park_q, park_d;
    logic            mis_q;
    logic            cap_inst, cap_mis, clr_mis;
    logic            req_hs;
    logic [XLEN-1:0] redir_tgt;
    logic            redir_mis, pc_mis;

`ifdef CORE_IF_MISALIGN_CHK_EN
    assign redir_tgt = i_redirect_pc;
    assign redir_mis = |i_redirect_pc[1:0];
    assign pc_mis    = |pc_q[1:0];
`else
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^i_redirect_pc[1:0];
    assign redir_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign redir_mis = 1'b0;
    assign pc_mis    = 1'b0;
`endif

    assign o_ifu_req_valid = (state_q == S_REQ) && !i_halt;
    assign o_ifu_req_addr  = pc_q;
    assign o_ifu_rsp_ready = (state_q == S_WAIT);
    assign o_if_valid      = (state_q == S_OUT);
    assign o_if_inst       = inst_q;
    assign o_if_pc         = opc_q;
    assign o_if_misalign   = mis_q;
    assign req_hs          = o_ifu_req_valid && i_ifu_req_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        park_d   = park_q;
        cap_inst = 1'b0;
        cap_mis  = 1'b0;
        clr_mis  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_redirect) begin
                    pc_d   = redir_tgt;
                    park_d = 1'b0;
                    if (redir_mis) begin
                        state_d = S_OUT;
                        cap_mis = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (!park_q) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_redirect) begin
                    pc_d = redir_tgt;
                    // An accepted request still owes a response; drain it before acting on the target.
                    if (req_hs) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end else if (redir_mis) begin
                        state_d = S_OUT;
                        cap_mis = 1'b1;
                    end
                end else if (req_hs) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect) begin
                    pc_d = redir_tgt;
                    if (i_ifu_rsp_valid) begin
                        kill_d = 1'b0;
                        if (redir_mis) begin
                            state_d = S_OUT;
                            cap_mis = 1'b1;
                        end else begin
                            state_d = S_REQ;
                        end
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (i_ifu_rsp_valid) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                        if (pc_mis) begin
                            state_d = S_OUT;
                            cap_mis = 1'b1;
                        end else begin
                            state_d = S_REQ;
                        end
                    end else begin
                        cap_inst = 1'b1;
                        pc_d     = pc_q + XLEN'(4);
                        state_d  = S_OUT;
                    end
                end
            end
            S_OUT: begin
                // A redirect here drops the buffered word even if decode is ready this cycle.
                if (i_redirect) begin
                    pc_d = redir_tgt;
                    if (redir_mis) begin
                        cap_mis = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        clr_mis = 1'b1;
                    end
                end else if (i_id_ready) begin
                    clr_mis = 1'b1;
                    if (mis_q) begin
                        state_d = S_IDLE;
                        park_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            park_q  <= 1'b0;
            inst_q  <= '0;
            opc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            park_q  <= park_d;
            if (cap_inst) begin
                inst_q <= i_ifu_rsp_inst;
                opc_q  <= pc_q;
                mis_q  <= 1'b0;
            end else if (cap_mis) begin
                inst_q <= '0;
                opc_q  <= pc_d;
                mis_q  <= 1'b1;
            end else if (clr_mis) begin
                mis_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_if_fetch.sv
// Directed bench for core_if_fetch: reset, streaming, stall, redirects, halt, misalign, mid-run reset.
module tb_core_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_ifu_req_valid;
    logic        i_ifu_req_ready;
    logic [31:0] o_ifu_req_addr;
    logic        i_ifu_rsp_valid;
    logic        o_ifu_rsp_ready;
    logic [31:0] i_ifu_rsp_inst;
    logic        o_if_valid;
    logic        i_id_ready;
    logic [31:0] o_if_inst;
    logic [31:0] o_if_pc;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        o_if_misalign;

    int checks   = 0;
    int failures = 0;

    core_if_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_ifu_req_valid(o_ifu_req_valid),
        .i_ifu_req_ready(i_ifu_req_ready),
        .o_ifu_req_addr (o_ifu_req_addr),
        .i_ifu_rsp_valid(i_ifu_rsp_valid),
        .o_ifu_rsp_ready(o_ifu_rsp_ready),
        .i_ifu_rsp_inst (i_ifu_rsp_inst),
        .o_if_valid     (o_if_valid),
        .i_id_ready     (i_id_ready),
        .o_if_inst      (o_if_inst),
        .o_if_pc        (o_if_pc),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .i_halt         (i_halt),
        .o_if_misalign  (o_if_misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; i_ifu_req_ready = 1'b0; i_ifu_rsp_valid = 1'b0; i_ifu_rsp_inst = '0;
        i_id_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0; i_halt = 1'b0;
        step(); step();
        chk("rst_req_valid", 32'(o_ifu_req_valid), 32'd0);
        chk("rst_rsp_ready", 32'(o_ifu_rsp_ready), 32'd0);
        chk("rst_req_addr", o_ifu_req_addr, 32'h8000_0000);
        chk("rst_if_valid", 32'(o_if_valid), 32'd0);
        chk("rst_if_inst", o_if_inst, 32'h0);
        chk("rst_if_pc", o_if_pc, 32'h0);
        chk("rst_misalign", 32'(o_if_misalign), 32'd0);

        // Zero-wait streaming
        rst_n = 1'b1; i_ifu_req_ready = 1'b1; i_id_ready = 1'b1;
        step();
        chk("s1_req_valid", 32'(o_ifu_req_valid), 32'd1);
        chk("s1_req_addr", o_ifu_req_addr, 32'h8000_0000);
        step();
        chk("s1_rsp_ready", 32'(o_ifu_rsp_ready), 32'd1);
        chk("s1_wait_req_valid", 32'(o_ifu_req_valid), 32'd0);
        i_ifu_rsp_valid = 1'b1; i_ifu_rsp_inst = 32'h0000_0013;
        step();
        i_ifu_rsp_valid = 1'b0;
        chk("s1_if_valid", 32'(o_if_valid), 32'd1);
        chk("s1_if_inst", o_if_inst, 32'h0000_0013);
        chk("s1_if_pc", o_if_pc, 32'h8000_0000);
        step();
        chk("s2_if_valid_low", 32'(o_if_valid), 32'd0);
        chk("s2_req_valid", 32'(o_ifu_req_valid), 32'd1);
        chk("s2_req_addr", o_ifu_req_addr, 32'h8000_0004);
        step();
        i_ifu_rsp_valid = 1'b1; i_ifu_rsp_inst = 32'h0010_0093;
        step();
        i_ifu_rsp_valid = 1'b0;
        chk("s2_if_pc", o_if_pc, 32'h8000_0004);
        chk("s2_if_inst", o_if_inst, 32'h0010_0093);

        // Decode stall for 5 cycles
        i_id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_if_valid", 32'(o_if_valid), 32'd1);
            chk("stall_if_inst", o_if_inst, 32'h0010_0093);
            chk("stall_if_pc", o_if_pc, 32'h8000_0004);
            chk("stall_req_valid", 32'(o_ifu_req_valid), 32'd0);
        end
        i_id_ready = 1'b1;
        step();
        chk("s3_req_addr", o_ifu_req_addr, 32'h8000_0008);
        chk("s3_req_valid", 32'(o_ifu_req_valid), 32'd1);

        // Redirect during WAIT
        step();
        chk("rw_rsp_ready", 32'(o_ifu_rsp_ready), 32'd1);
        i_redirect = 1'b1; i_redirect_pc = 32'h8000_0100;
        step();
        i_redirect = 1'b0;
        chk("rw_still_wait", 32'(o_ifu_rsp_ready), 32'd1);
        chk("rw_pc_loaded", o_ifu_req_addr, 32'h8000_0100);
        i_ifu_rsp_valid = 1'b1; i_ifu_rsp_inst = 32'hDEAD_BEEF;
        step();
        i_ifu_rsp_valid = 1'b0;
        chk("rw_stale_dropped", 32'(o_if_valid), 32'd0);
        chk("rw_req_valid", 32'(o_ifu_req_valid), 32'd1);
        chk("rw_req_addr", o_ifu_req_addr, 32'h8000_0100);

        // Redirect in OUT with decode ready the same cycle
        step();
        i_ifu_rsp_valid = 1'b1; i_ifu_rsp_inst = 32'h1111_1111;
        step();
        i_ifu_rsp_valid = 1'b0;
        chk("ro_if_valid", 32'(o_if_valid), 32'd1);
        chk("ro_if_pc", o_if_pc, 32'h8000_0100);
        i_redirect = 1'b1; i_redirect_pc = 32'h8000_0200;
        step();
        i_redirect = 1'b0;
        chk("ro_if_valid_low", 32'(o_if_valid), 32'd0);
        chk("ro_req_valid", 32'(o_ifu_req_valid), 32'd1);
        chk("ro_req_addr", o_ifu_req_addr, 32'h8000_0200);

        // Halt in REQ for 10 cycles with memory ready
        i_halt = 1'b1;
        #1;
        chk("halt_req_valid0", 32'(o_ifu_req_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_req_valid", 32'(o_ifu_req_valid), 32'd0);
            chk("halt_req_addr", o_ifu_req_addr, 32'h8000_0200);
        end
        i_halt = 1'b0;
        #1;
        chk("resume_req_valid", 32'(o_ifu_req_valid), 32'd1);
        chk("resume_req_addr", o_ifu_req_addr, 32'h8000_0200);
        step();
        i_ifu_rsp_valid = 1'b1; i_ifu_rsp_inst = 32'h2222_2222;
        step();
        i_ifu_rsp_valid = 1'b0;
        chk("resume_if_pc", o_if_pc, 32'h8000_0200);
        chk("resume_if_inst", o_if_inst, 32'h2222_2222);

        // Misaligned redirect from OUT
        i_redirect = 1'b1; i_redirect_pc = 32'h8000_0102;
        step();
        i_redirect = 1'b0;
`ifdef CORE_IF_MISALIGN_CHK_EN
        chk("mis_if_valid", 32'(o_if_valid), 32'd1);
        chk("mis_flag", 32'(o_if_misalign), 32'd1);
        chk("mis_if_pc", o_if_pc, 32'h8000_0102);
        chk("mis_if_inst", o_if_inst, 32'h0);
        chk("mis_no_req", 32'(o_ifu_req_valid), 32'd0);
        step();
        chk("mis_clr_valid", 32'(o_if_valid), 32'd0);
        chk("mis_clr_flag", 32'(o_if_misalign), 32'd0);
        step();
        chk("mis_parked", 32'(o_ifu_req_valid), 32'd0);
        i_redirect = 1'b1; i_redirect_pc = 32'h8000_0300;
        step();
        i_redirect = 1'b0;
        chk("mis_resume_valid", 32'(o_ifu_req_valid), 32'd1);
        chk("mis_resume_addr", o_ifu_req_addr, 32'h8000_0300);
`else
        chk("mis_off_req_valid", 32'(o_ifu_req_valid), 32'd1);
        chk("mis_off_req_addr", o_ifu_req_addr, 32'h8000_0100);
        chk("mis_off_flag", 32'(o_if_misalign), 32'd0);
        chk("mis_off_if_valid", 32'(o_if_valid), 32'd0);
`endif

        // Reset mid-operation while a response is outstanding
        step();
        chk("mr_in_wait", 32'(o_ifu_rsp_ready), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mr_rsp_ready", 32'(o_ifu_rsp_ready), 32'd0);
        chk("mr_req_addr", o_ifu_req_addr, 32'h8000_0000);
        chk("mr_if_pc", o_if_pc, 32'h0);
        chk("mr_if_inst", o_if_inst, 32'h0);
        rst_n = 1'b1; i_ifu_rsp_valid = 1'b1; i_ifu_rsp_inst = 32'h3333_3333;
        step();
        i_ifu_rsp_valid = 1'b0;
        chk("mr_late_rsp_ignored", 32'(o_if_valid), 32'd0);
        chk("mr_req_valid", 32'(o_ifu_req_valid), 32'd1);
        chk("mr_req_addr2", o_ifu_req_addr, 32'h8000_0000);
        step();
        i_ifu_rsp_valid = 1'b1; i_ifu_rsp_inst = 32'h4444_4444;
        step();
        i_ifu_rsp_valid = 1'b0;
        chk("mr_if_inst2", o_if_inst, 32'h4444_4444);
        chk("mr_if_pc2", o_if_pc, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
